// File: rtl/multi_channel_fir_filter_if.sv
// ----------------------------------------------------------------------------
// multi_channel_fir_filter_if
// AXI-Stream style sample bus used on both sides of the multi-channel FIR.
//   data  : signed sample, DATA_WIDTH bits
//   valid : producer has a sample on data
//   ready : consumer accepts the sample this cycle when high with valid
//   last  : marks the final channel of an interleaved frame
// Modports: master drives data/valid/last, slave drives ready.
// ----------------------------------------------------------------------------
interface multi_channel_fir_filter_if #(
  parameter int DATA_WIDTH = 24
);
  logic signed [DATA_WIDTH-1:0] data;
  logic                         valid;
  logic                         ready;
  logic                         last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/multi_channel_fir_filter.sv
// ----------------------------------------------------------------------------
// multi_channel_fir_filter
// Time-multiplexed FIR for interleaved multi-channel audio. Each channel owns
// a TAPS-deep delay line; one serial MAC is shared by all channels and taps.
// Coefficients live in NUM_BANKS runtime-writable banks, selected by modes
// at sample accept time. Every bank resets to pass-through (tap0 = ~1.0).
//
// Ports:
//   clk           sole clock
//   reset         synchronous, active-high; aborts any in-flight sample
//   modes         coefficient bank used for the next accepted sample
//   fpga          sample input stream (slave), last = final channel of frame
//   pmod          filtered output stream (master), last = channel NUM_CHANNELS-1
//   coef_wr_*     coefficient write port, accepted only while idle
//   sync_err      one-cycle pulse when input last disagrees with channel count
//
// Build option: define FIR_SATURATE_EN to clamp out-of-range results to the
// DATA_WIDTH signed range; otherwise the low DATA_WIDTH bits are kept (wrap).
// ----------------------------------------------------------------------------
module multi_channel_fir_filter #(
  parameter int DATA_WIDTH   = 24,
  parameter int COEF_WIDTH   = 16,
  parameter int TAPS         = 16,
  parameter int NUM_CHANNELS = 2,
  parameter int NUM_BANKS    = 4,
  localparam int BANK_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int TAP_W       = $clog2(TAPS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [BANK_W-1:0]            modes,
  multi_channel_fir_filter_if.slave    fpga,
  multi_channel_fir_filter_if.master   pmod,
  input  logic                         coef_wr_en,
  input  logic [BANK_W-1:0]            coef_wr_bank,
  input  logic [TAP_W-1:0]             coef_wr_tap,
  input  logic signed [COEF_WIDTH-1:0] coef_wr_data,
  output logic                         coef_wr_ready,
  output logic                         sync_err
);

  localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
  localparam int ACC_W  = DATA_WIDTH + COEF_WIDTH + $clog2(TAPS);
  localparam logic signed [ACC_W-1:0] ROUND_CONST = ACC_W'(2 ** (COEF_WIDTH - 2));
  localparam logic signed [COEF_WIDTH-1:0] COEF_ONE = {1'b0, {(COEF_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND, S_OUT} state_t;

  state_t                   state_reg, state_next;
  logic                     fpga_ready_c, coef_wr_ready_c, pmod_valid_c;
  logic                     accept, coef_wr_accept, ch_is_last;
  logic [CH_W-1:0]          ch_reg, ch_lat_reg;
  logic [BANK_W-1:0]        bank_lat_reg;
  logic [TAP_W-1:0]         tap_cnt_reg;
  logic signed [ACC_W-1:0]  acc_reg;
  logic signed [DATA_WIDTH-1:0] pmod_data_reg;
  logic                     pmod_last_reg, sync_err_reg;

  // Per-channel / per-bank values at the current tap, flattened for muxing.
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] chan_taps;
  logic [NUM_BANKS*COEF_WIDTH-1:0]    bank_coefs;
  logic signed [DATA_WIDTH-1:0]       sample_sel;
  logic signed [COEF_WIDTH-1:0]       coef_sel;
  logic signed [PROD_W-1:0]           product;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next      = state_reg;
    fpga_ready_c    = 1'b0;
    coef_wr_ready_c = 1'b0;
    pmod_valid_c    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // Held low while reset is asserted so nothing is accepted then.
        fpga_ready_c    = !reset;
        coef_wr_ready_c = !reset;
        if (fpga.valid && !reset) state_next = S_MAC;
      end
      S_MAC:   if (tap_cnt_reg == TAP_W'(TAPS - 1)) state_next = S_ROUND;
      S_ROUND: state_next = S_OUT;
      S_OUT: begin
        pmod_valid_c = 1'b1;
        if (pmod.ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign accept         = fpga.valid && fpga_ready_c;
  assign coef_wr_accept = coef_wr_en && coef_wr_ready_c;
  assign ch_is_last     = (ch_reg == CH_W'(NUM_CHANNELS - 1));

  // ---------------- delay lines, one per channel ----------------
  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
    logic signed [DATA_WIDTH-1:0] line_reg [TAPS];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k < TAPS; k++) line_reg[k] <= '0;
      end else if (accept && (ch_reg == CH_W'(gi))) begin
        line_reg[0] <= fpga.data;
        for (int k = 1; k < TAPS; k++) line_reg[k] <= line_reg[k-1];
      end
    end
    assign chan_taps[gi*DATA_WIDTH +: DATA_WIDTH] = line_reg[tap_cnt_reg];
  end

  // ---------------- coefficient banks ----------------
  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic signed [COEF_WIDTH-1:0] coef_reg [TAPS];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k < TAPS; k++) coef_reg[k] <= (k == 0) ? COEF_ONE : '0;
      end else if (coef_wr_accept && (coef_wr_bank == BANK_W'(gi))) begin
        coef_reg[coef_wr_tap] <= coef_wr_data;
      end
    end
    assign bank_coefs[gi*COEF_WIDTH +: COEF_WIDTH] = coef_reg[tap_cnt_reg];
  end

  assign sample_sel = $signed(chan_taps[ch_lat_reg*DATA_WIDTH +: DATA_WIDTH]);
  assign coef_sel   = $signed(bank_coefs[bank_lat_reg*COEF_WIDTH +: COEF_WIDTH]);
  assign product    = PROD_W'(sample_sel) * PROD_W'(coef_sel);

  // ---------------- rounding and narrowing ----------------
  logic signed [ACC_W-1:0]      rounded, shifted;
  logic signed [DATA_WIDTH-1:0] narrowed;

  assign rounded = acc_reg + ROUND_CONST;
  assign shifted = rounded >>> (COEF_WIDTH - 1);

`ifdef FIR_SATURATE_EN
  // In range only when every bit from the result sign upward agrees.
  logic [ACC_W-DATA_WIDTH:0] upper;
  assign upper = shifted[ACC_W-1:DATA_WIDTH-1];
  always_comb begin
    narrowed = shifted[DATA_WIDTH-1:0];
    if (!upper[ACC_W-DATA_WIDTH] && (|upper))
      narrowed = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (upper[ACC_W-DATA_WIDTH] && !(&upper))
      narrowed = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  end
`else
  logic unused_high;
  assign unused_high = ^shifted[ACC_W-1:DATA_WIDTH];
  assign narrowed    = shifted[DATA_WIDTH-1:0];
`endif

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ch_reg        <= '0;
      ch_lat_reg    <= '0;
      bank_lat_reg  <= '0;
      tap_cnt_reg   <= '0;
      acc_reg       <= '0;
      pmod_data_reg <= '0;
      pmod_last_reg <= 1'b0;
      sync_err_reg  <= 1'b0;
    end else begin
      sync_err_reg <= accept && (fpga.last != ch_is_last);
      if (accept) begin
        // The sample is filtered with the pre-update channel index.
        ch_lat_reg   <= ch_reg;
        bank_lat_reg <= modes;
        acc_reg      <= '0;
        tap_cnt_reg  <= '0;
        ch_reg       <= (fpga.last || ch_is_last) ? '0 : ch_reg + 1'b1;
      end
      if (state_reg == S_MAC) begin
        acc_reg     <= acc_reg + ACC_W'(product);
        tap_cnt_reg <= tap_cnt_reg + 1'b1;
      end
      if (state_reg == S_ROUND) begin
        pmod_data_reg <= narrowed;
        pmod_last_reg <= (ch_lat_reg == CH_W'(NUM_CHANNELS - 1));
      end
    end
  end

  assign fpga.ready    = fpga_ready_c;
  assign coef_wr_ready = coef_wr_ready_c;
  assign pmod.valid    = pmod_valid_c;
  assign pmod.data     = pmod_data_reg;
  assign pmod.last     = pmod_last_reg;
  assign sync_err      = sync_err_reg;

endmodule

// File: tb/tb_multi_channel_fir_filter.sv
// ----------------------------------------------------------------------------
// tb_multi_channel_fir_filter
// Directed bench for multi_channel_fir_filter with default parameters
// (24-bit samples, 16-bit coefficients, 16 taps, 2 channels, 4 banks).
// ----------------------------------------------------------------------------
module tb_multi_channel_fir_filter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  modes;
  logic        coef_wr_en;
  logic [1:0]  coef_wr_bank;
  logic [3:0]  coef_wr_tap;
  logic signed [15:0] coef_wr_data;
  logic        coef_wr_ready;
  logic        sync_err;

  multi_channel_fir_filter_if #(.DATA_WIDTH(24)) fpga_bus ();
  multi_channel_fir_filter_if #(.DATA_WIDTH(24)) pmod_bus ();

  multi_channel_fir_filter dut (
    .clk          (clk),
    .reset        (reset),
    .modes        (modes),
    .fpga         (fpga_bus),
    .pmod         (pmod_bus),
    .coef_wr_en   (coef_wr_en),
    .coef_wr_bank (coef_wr_bank),
    .coef_wr_tap  (coef_wr_tap),
    .coef_wr_data (coef_wr_data),
    .coef_wr_ready(coef_wr_ready),
    .sync_err     (sync_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Results captured by the driver tasks.
  int   acc_cyc;
  logic ready_after, sync1, sync2;
  logic signed [23:0] out_d;
  logic out_l;
  int   out_cyc;

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic write_coef(input logic [1:0] b, input logic [3:0] t, input logic signed [15:0] v);
    int n = 0;
    coef_wr_en = 1'b1; coef_wr_bank = b; coef_wr_tap = t; coef_wr_data = v;
    while (coef_wr_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL coef_wr_timeout: coef_wr_ready=%b required 1", coef_wr_ready);
    end
    @(posedge clk); #1;
    coef_wr_en = 1'b0;
  endtask

  task automatic send(input logic signed [23:0] d, input logic l);
    int n = 0;
    fpga_bus.data = d; fpga_bus.last = l; fpga_bus.valid = 1'b1;
    while (fpga_bus.ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL send_timeout: fpga_ready=%b required 1", fpga_bus.ready);
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    fpga_bus.valid = 1'b0;
    ready_after = fpga_bus.ready;
    sync1 = sync_err;
    @(posedge clk); #1;
    sync2 = sync_err;
  endtask

  task automatic recv();
    int n = 0;
    while (pmod_bus.valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL recv_timeout: pmod_valid=%b required 1", pmod_bus.valid);
    end
    out_d = pmod_bus.data; out_l = pmod_bus.last; out_cyc = cyc;
    $display("txn out data=%0d last=%0d cycle=%0d", out_d, out_l, out_cyc);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (fpga_bus.ready !== 1'b0) begin errors++; $display("FAIL rst_fpga_ready: got %b required 0", fpga_bus.ready); end
    checks++; if (pmod_bus.valid !== 1'b0) begin errors++; $display("FAIL rst_pmod_valid: got %b required 0", pmod_bus.valid); end
    checks++; if (pmod_bus.data !== 24'sd0) begin errors++; $display("FAIL rst_pmod_data: got %0d required 0", pmod_bus.data); end
    checks++; if (pmod_bus.last !== 1'b0) begin errors++; $display("FAIL rst_pmod_last: got %b required 0", pmod_bus.last); end
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL rst_sync_err: got %b required 0", sync_err); end
    checks++; if (coef_wr_ready !== 1'b0) begin errors++; $display("FAIL rst_coef_wr_ready: got %b required 0", coef_wr_ready); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (fpga_bus.ready !== 1'b1) begin errors++; $display("FAIL post_rst_fpga_ready: got %b required 1", fpga_bus.ready); end
  endtask

  task automatic test_stereo();
    modes = 2'd0;
    send(24'sd1000, 1'b0);
    checks++; if (ready_after !== 1'b0) begin errors++; $display("FAIL busy_fpga_ready: got %b required 0", ready_after); end
    checks++; if (sync1 !== 1'b0) begin errors++; $display("FAIL stereo_l_sync: got %b required 0", sync1); end
    recv();
    checks++; if (out_d !== 24'sd1000) begin errors++; $display("FAIL stereo_l_data: got %0d required 1000", out_d); end
    checks++; if (out_l !== 1'b0) begin errors++; $display("FAIL stereo_l_last: got %b required 0", out_l); end
    checks++; if (out_cyc - acc_cyc != 18) begin errors++; $display("FAIL stereo_l_latency: got %0d required 18", out_cyc - acc_cyc); end
    send(-24'sd1000, 1'b1);
    checks++; if (sync1 !== 1'b0) begin errors++; $display("FAIL stereo_r_sync: got %b required 0", sync1); end
    recv();
    checks++; if (out_d !== -24'sd1000) begin errors++; $display("FAIL stereo_r_data: got %0d required -1000", out_d); end
    checks++; if (out_l !== 1'b1) begin errors++; $display("FAIL stereo_r_last: got %b required 1", out_l); end
    checks++; if (out_cyc - acc_cyc != 18) begin errors++; $display("FAIL stereo_r_latency: got %0d required 18", out_cyc - acc_cyc); end
  endtask

  task automatic test_backpressure();
    logic signed [23:0] held;
    int n = 0;
    modes = 2'd0;
    pmod_bus.ready = 1'b0;
    send(24'sd3000, 1'b0);
    while (pmod_bus.valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    checks++; if (pmod_bus.valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b required 1", pmod_bus.valid); end
    held = pmod_bus.data;
    checks++; if (held !== 24'sd3000) begin errors++; $display("FAIL bp_data: got %0d required 3000", held); end
    // Attempt to zero bank 0 tap 0 while output is stalled; must be ignored.
    coef_wr_en = 1'b1; coef_wr_bank = 2'd0; coef_wr_tap = 4'd0; coef_wr_data = 16'sd0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      checks++; if (pmod_bus.valid !== 1'b1 || pmod_bus.data !== held) begin errors++; $display("FAIL bp_hold_data: got valid=%b data=%0d required valid=1 data=%0d", pmod_bus.valid, pmod_bus.data, held); end
      checks++; if (fpga_bus.ready !== 1'b0) begin errors++; $display("FAIL bp_hold_fpga_ready: got %b required 0", fpga_bus.ready); end
      checks++; if (coef_wr_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_coef_ready: got %b required 0", coef_wr_ready); end
    end
    coef_wr_en = 1'b0;
    pmod_bus.ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (pmod_bus.valid !== 1'b0 || fpga_bus.ready !== 1'b1) begin errors++; $display("FAIL bp_release_idle: got valid=%b ready=%b required valid=0 ready=1", pmod_bus.valid, fpga_bus.ready); end
    send(24'sd777, 1'b1);
    recv();
    checks++; if (out_d !== 24'sd777) begin errors++; $display("FAIL bp_coef_ignored: got %0d required 777", out_d); end
    checks++; if (out_l !== 1'b1) begin errors++; $display("FAIL bp_last: got %b required 1", out_l); end
  endtask

  task automatic test_sync_err();
    modes = 2'd0;
    send(24'sd100, 1'b1);
    checks++; if (sync1 !== 1'b1) begin errors++; $display("FAIL sync_pulse: got %b required 1", sync1); end
    checks++; if (sync2 !== 1'b0) begin errors++; $display("FAIL sync_one_cycle: got %b required 0", sync2); end
    recv();
    checks++; if (out_d !== 24'sd100) begin errors++; $display("FAIL sync_data: got %0d required 100", out_d); end
    checks++; if (out_l !== 1'b0) begin errors++; $display("FAIL sync_out_last: got %b required 0", out_l); end
    send(24'sd200, 1'b0);
    checks++; if (sync1 !== 1'b0) begin errors++; $display("FAIL sync_next_clean: got %b required 0", sync1); end
    recv();
    checks++; if (out_l !== 1'b0) begin errors++; $display("FAIL sync_next_ch0: got last=%b required 0", out_l); end
    send(24'sd300, 1'b1);
    checks++; if (sync1 !== 1'b0) begin errors++; $display("FAIL sync_ch1_clean: got %b required 0", sync1); end
    recv();
    checks++; if (out_l !== 1'b1) begin errors++; $display("FAIL sync_ch1_last: got %b required 1", out_l); end
  endtask

  task automatic test_bank_select();
    logic signed [23:0] exp_ch0 [5];
    exp_ch0[0] = 24'sd0; exp_ch0[1] = 24'sd0; exp_ch0[2] = 24'sd0;
    exp_ch0[3] = 24'sd2000; exp_ch0[4] = 24'sd0;
    do_reset();
    write_coef(2'd1, 4'd0, 16'sd0);
    write_coef(2'd1, 4'd3, 16'sd16384);
    modes = 2'd1;
    for (int i = 0; i < 5; i++) begin
      send((i == 0) ? 24'sd4000 : 24'sd0, 1'b0);
      recv();
      checks++; if (out_d !== exp_ch0[i] || out_l !== 1'b0) begin errors++; $display("FAIL bank_ch0[%0d]: got %0d last=%b required %0d last=0", i, out_d, out_l, exp_ch0[i]); end
      send(24'sd0, 1'b1);
      recv();
      checks++; if (out_d !== 24'sd0 || out_l !== 1'b1) begin errors++; $display("FAIL bank_ch1[%0d]: got %0d last=%b required 0 last=1", i, out_d, out_l); end
    end
  endtask

  task automatic test_saturate();
    longint s;
    logic signed [23:0] e;
    do_reset();
    for (int t = 0; t < 16; t++) write_coef(2'd2, 4'(t), 16'sd32767);
    modes = 2'd2;
    for (int k = 1; k <= 16; k++) begin
      send(24'sd8388607, 1'b0);
      recv();
      s = (longint'(k) * 64'sd8388607 * 64'sd32767 + 64'sd16384) >>> 15;
`ifdef FIR_SATURATE_EN
      if (s > 64'sd8388607) e = 24'sd8388607;
      else if (s < -64'sd8388608) e = -24'sd8388608;
      else e = s[23:0];
`else
      e = s[23:0];
`endif
      if (k == 16) begin
`ifdef FIR_SATURATE_EN
        e = 24'sd8388607;
`else
        e = -24'sd4112;
`endif
      end
      checks++; if (out_d !== e) begin errors++; $display("FAIL sat_ch0[%0d]: got %0d required %0d", k, out_d, e); end
      send(24'sd0, 1'b1);
      recv();
      checks++; if (out_d !== 24'sd0) begin errors++; $display("FAIL sat_ch1[%0d]: got %0d required 0", k, out_d); end
    end
  endtask

  task automatic test_reset_mid_mac();
    modes = 2'd0;
    send(24'sd1234, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      checks++; if (pmod_bus.valid !== 1'b0) begin errors++; $display("FAIL abort_valid[%0d]: got %b required 0", i, pmod_bus.valid); end
      @(posedge clk); #1;
    end
    // A nonzero tap 1 exposes any stale sample left in the ch0 delay line.
    write_coef(2'd0, 4'd1, 16'sd32767);
    send(24'sd500, 1'b0);
    recv();
    checks++; if (out_d !== 24'sd500) begin errors++; $display("FAIL abort_data: got %0d required 500", out_d); end
    checks++; if (out_l !== 1'b0) begin errors++; $display("FAIL abort_last: got %b required 0", out_l); end
  endtask

  initial begin
    reset = 1'b1;
    modes = 2'd0;
    fpga_bus.data = '0; fpga_bus.valid = 1'b0; fpga_bus.last = 1'b0;
    pmod_bus.ready = 1'b1;
    coef_wr_en = 1'b0; coef_wr_bank = '0; coef_wr_tap = '0; coef_wr_data = '0;
    test_reset();
    test_stereo();
    test_backpressure();
    test_sync_err();
    test_bank_select();
    test_saturate();
    test_reset_mid_mac();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/multi_channel_fir_filter.md
# multi_channel_fir_filter

Parametrised, time-multiplexed FIR filter for interleaved multi-channel audio on the AXI-Stream path between the I2S2 receiver and transmitter. It generalises the single-channel filter to N channels, each with its own delay line, and adds runtime-writable coefficient banks selected by the mode switches. A single serial multiply-accumulate (MAC) unit is shared across all channels and taps.

## Interface
- DATA_WIDTH, 24, signed sample width
- COEF_WIDTH, 16, signed coefficient width, Q1.(COEF_WIDTH-1)
- TAPS, 16, taps per channel (≥2)
- NUM_CHANNELS, 2, interleaved channels per frame (≥1)
- NUM_BANKS, 4, coefficient banks (power of two)
- clk  in  1  sole clock (axis_clk domain)
- reset  in  1  synchronous, active-high
- modes  in  clog2(NUM_BANKS)  coefficient bank select
- fpga_data / fpga_valid / fpga_ready / fpga_last  in/in/out/in  DATA_WIDTH/1/1/1  AXIS slave; last marks final channel of a frame
- pmod_data / pmod_valid / pmod_ready / pmod_last  out/out/in/out  DATA_WIDTH/1/1/1  AXIS master
- coef_wr_en  in  1  coefficient write strobe
- coef_wr_bank  in  clog2(NUM_BANKS)  target bank
- coef_wr_tap  in  clog2(TAPS)  target tap
- coef_wr_data  in  COEF_WIDTH  coefficient value
- coef_wr_ready  out  1  write accepted this cycle when high with coef_wr_en
- sync_err  out  1  one-cycle pulse on a channel/last mismatch

## Operation
- FSM states: IDLE → MAC → ROUND → OUT → IDLE.
- IDLE: fpga_ready=1. On fpga_valid:
  - shift fpga_data into the delay line of the current channel index `ch`; tap 0 is the newest sample;
  - latch `ch`, fpga_last and modes;
  - clear the accumulator.
- MAC: TAPS cycles, tap k = 0..TAPS-1. Each cycle, acc += delay[ch][k] × coef[bank][k].
- Accumulator width: DATA_WIDTH+COEF_WIDTH+clog2(TAPS).
- ROUND: add 2^(COEF_WIDTH-2), then arithmetic shift right by COEF_WIDTH-1, then narrow to DATA_WIDTH (see Configuration). Register the result into pmod_data.
- OUT: pmod_valid=1, pmod_last = (latched ch == NUM_CHANNELS-1). pmod_data and pmod_last hold stable until pmod_ready; then go to IDLE.
- Channel index update on accept:
  - fpga_last=1 or ch==NUM_CHANNELS-1: ch←0.
  - Otherwise: ch←ch+1.
  - fpga_last≠(ch==NUM_CHANNELS-1): pulse sync_err the cycle after accept. The sample is still processed with the old ch; the next sample uses the updated ch.
- Coefficients:
  - TAPS×NUM_BANKS registers.
  - coef_wr_ready=1 only in IDLE.
  - A write on accept-cycle is valid and applies to that sample's MAC.
  - Writes in other states are ignored.
- Bank change on modes during MAC/OUT has no effect until the next accept.

## Timing
- Reset values:
  - pmod_data=0, pmod_valid=0, pmod_last=0, fpga_ready=0 during reset, sync_err=0, ch=0, state=IDLE.
  - All delay lines = 0.
  - Every bank: tap0 = 2^(COEF_WIDTH-1)-1, other taps 0, i.e. pass-through.
- fpga_ready=1 from the first cycle after reset deasserts.
- Latency: accept at cycle T → pmod_valid high at T+TAPS+2 (1 capture, TAPS MAC, 1 round).
- Throughput: one sample per TAPS+3 cycles minimum, with pmod_ready tied high. With TAPS=16 and an axis_clk of 12.5 MHz this is well above 2×48 kHz.
- fpga_ready=0 in MAC/ROUND/OUT, so back-pressure propagates upstream.
- pmod_valid stays high with no data change until pmod_ready. Handshake at cycle U → IDLE at U+1.
- Reset asserted in any state aborts the operation:
  - the next cycle is in IDLE with the reset values above;
  - any in-flight output is dropped;
  - coefficients return to pass-through.

## Configuration
- FIR_SATURATE_EN defined: a shifted result outside the DATA_WIDTH signed range clamps to +2^(DATA_WIDTH-1)-1 or −2^(DATA_WIDTH-1).
- Not defined: the low DATA_WIDTH bits are kept (two's-complement wrap).
- Both cases yield identical results for in-range values.

## Test plan
- Reset, then stereo frame L=1000 (last=0), R=−1000 (last=1):
  - outputs 1000 then −1000 via rounding;
  - pmod_last 0 then 1;
  - each valid 18 cycles after its accept.
- Bank 1, tap3=16384 (0.5), others 0; modes=1; on ch0, stream 4000 then zeros (last toggling per frame):
  - ch0 outputs 0,0,0,2000,0;
  - ch1 outputs all 0, confirming independent delay lines.
- Bank 2, all 16 taps=32767; ch0 fed 16 samples of 2^23−1 (ch1 fed 0):
  - with FIR_SATURATE_EN the 16th ch0 output is 8388607;
  - without it the output is the wrapped low 24 bits (reference model).
- Hold pmod_ready=0 for 50 cycles during OUT:
  - pmod_data stable, fpga_ready=0, coef writes ignored (coef_wr_ready=0);
  - releasing pmod_ready returns to IDLE next cycle.
- Send fpga_last=1 on ch0:
  - sync_err pulses once, that output has pmod_last=0;
  - the next sample is processed as ch0.
- Assert reset mid-MAC:
  - pmod_valid stays 0, delay lines are cleared;
  - the first post-reset sample 500 outputs 500.
